// File: rtl/vz_pkg.sv
// Shared definitions for the VZ snapshot (.VZ file) loader.
// Holds the FSM state type, the file-header byte offsets, the accepted type codes and magic
// words, and the ROM-variable patch addresses, plus helpers that map a patch step to an
// address and a data byte.
package vz_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StData,
      StWrite,
      StPatch,
      StDone,
      StErr
   } vz_state_e;

   // File header layout (byte offsets into the download stream)
   localparam logic [15:0] OffMagicLast = 16'd3;
   localparam logic [15:0] OffType      = 16'd21;
   localparam logic [15:0] OffStartLo   = 16'd22;
   localparam logic [15:0] OffStartHi   = 16'd23;
   localparam logic [15:0] OffData      = 16'd24;

   localparam logic [7:0] TypeBasic = 8'hF0;
   localparam logic [7:0] TypeBin   = 8'hF1;

   // Magic words packed first-byte-first: "VZF0" and 20h,20h,00h,00h
   localparam logic [31:0] MagicVzf0  = 32'h565A_4630;
   localparam logic [31:0] MagicBlank = 32'h2020_0000;

   localparam logic [15:0] PatchBasicStart = 16'h78A4;
   localparam logic [15:0] PatchBasicEnd   = 16'h78F9;
   localparam logic [15:0] PatchBinStart   = 16'h788E;

   // Step 0/1 write start lo/hi, step 2/3 write end lo/hi (BASIC only)
   function automatic logic [15:0] patch_addr(input logic [7:0] ftype, input logic [1:0] idx);
      logic [15:0] base;
      base = idx[1] ? PatchBasicEnd : PatchBasicStart;
      if (ftype == TypeBin) base = PatchBinStart;
      return base + {15'd0, idx[0]};
   endfunction

   function automatic logic [7:0] patch_data(input logic [1:0]  idx,
                                             input logic [15:0] start,
                                             input logic [15:0] end_addr);
      logic [15:0] word;
      word = idx[1] ? end_addr : start;
      return idx[0] ? word[15:8] : word[7:0];
   endfunction

   function automatic logic [1:0] patch_last(input logic [7:0] ftype);
      return (ftype == TypeBin) ? 2'd1 : 2'd3;
   endfunction

endpackage

// File: rtl/vz_loader_if.sv
// Bus bundle between the HPS download stream, the memory arbiter and the VZ loader.
//   dn_*    : HPS byte stream (download flag, slot index, byte strobe, offset, data) + dn_wait
//   mem_*   : single-outstanding RAM write request (req/addr/wdata) with one-cycle mem_ack
// modport master: the HPS/arbiter side; modport slave: the loader.
interface vz_loader_if;
   logic        dn_download;
   logic [7:0]  dn_index;
   logic        dn_wr;
   logic [15:0] dn_addr;
   logic [7:0]  dn_data;
   logic        dn_wait;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_ack;

   modport master (
      output dn_download, dn_index, dn_wr, dn_addr, dn_data, mem_ack,
      input  dn_wait, mem_req, mem_addr, mem_wdata
   );

   modport slave (
      input  dn_download, dn_index, dn_wr, dn_addr, dn_data, mem_ack,
      output dn_wait, mem_req, mem_addr, mem_wdata
   );
endinterface

// File: rtl/vz_loader.sv
// VZ snapshot loader: parses the .VZ header from the HPS download stream, writes the data
// bytes into RAM through the memory arbiter, then patches the ROM pointer variables so the
// loaded BASIC program or binary is usable. Holds the Z80 off the bus while active.
// Ports:
//   CLK10MHZ  : system clock
//   RESET     : asynchronous active-low reset
//   bus       : vz_loader_if slave (HPS download stream + RAM write handshake)
//   cpu_wait  : holds the Z80 off the bus
//   busy      : loader active
//   done      : one-cycle completion pulse
//   err       : sticky error flag, cleared when the next valid download starts
module vz_loader
   import vz_pkg::*;
(
   input  logic    CLK10MHZ,
   input  logic    RESET,
   vz_loader_if.slave bus,
   output logic    cpu_wait,
   output logic    busy,
   output logic    done,
   output logic    err
);

   vz_state_e   state_q;
   logic [23:0] magic_q;
   logic [7:0]  type_q;
   logic [15:0] start_q;
   logic [15:0] data_len_q;
   logic [1:0]  patch_idx_q;
   logic        dn_wait_q;
   logic        mem_req_q;
   logic [15:0] mem_addr_q;
   logic [7:0]  mem_wdata_q;
   logic        cpu_wait_q;
   logic        busy_q;
   logic        done_q;
   logic        err_q;

   logic [31:0] magic_word;
   logic        magic_ok;
   logic        type_ok;
   logic [15:0] data_addr;
   logic [15:0] end_addr;

   always_comb begin
      magic_word = {magic_q, bus.dn_data};
      magic_ok   = (magic_word == MagicVzf0) || (magic_word == MagicBlank);
      type_ok    = (bus.dn_data == TypeBasic) || (bus.dn_data == TypeBin);
      data_addr  = start_q + (bus.dn_addr - OffData);
      end_addr   = start_q + data_len_q;
   end

   always_ff @(posedge CLK10MHZ or negedge RESET) begin
      if (!RESET) begin
         state_q     <= StIdle;
         magic_q     <= '0;
         type_q      <= '0;
         start_q     <= '0;
         data_len_q  <= '0;
         patch_idx_q <= '0;
         dn_wait_q   <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_wait_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.dn_download && (bus.dn_index == 8'd1)) begin
                  err_q       <= 1'b0;
                  data_len_q  <= '0;
                  patch_idx_q <= '0;
                  cpu_wait_q  <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= StHdr;
               end
            end
            StHdr: begin
               if (!bus.dn_download) begin
                  // Truncated header
                  err_q   <= 1'b1;
                  state_q <= StErr;
               end else if (bus.dn_wr) begin
                  if (bus.dn_addr < OffMagicLast) begin
                     magic_q <= {magic_q[15:0], bus.dn_data};
                  end else if (bus.dn_addr == OffMagicLast) begin
                     if (!magic_ok) begin
                        err_q   <= 1'b1;
                        state_q <= StErr;
                     end
                  end else if (bus.dn_addr == OffType) begin
                     type_q <= bus.dn_data;
                     if (!type_ok) begin
                        err_q   <= 1'b1;
                        state_q <= StErr;
                     end
                  end else if (bus.dn_addr == OffStartLo) begin
                     start_q[7:0] <= bus.dn_data;
                  end else if (bus.dn_addr == OffStartHi) begin
                     start_q[15:8] <= bus.dn_data;
                     state_q       <= StData;
                  end
               end
            end
            StData: begin
               if (!bus.dn_download) begin
                  state_q <= StPatch;
               end else if (bus.dn_wr) begin
                  mem_addr_q  <= data_addr;
                  mem_wdata_q <= bus.dn_data;
                  mem_req_q   <= 1'b1;
                  dn_wait_q   <= 1'b1;
                  state_q     <= StWrite;
               end
            end
            StWrite: begin
               // A byte strobed while stalled is dropped; the pending write still finishes
               if (bus.dn_wr) err_q <= 1'b1;
               if (bus.mem_ack) begin
                  mem_req_q  <= 1'b0;
                  dn_wait_q  <= 1'b0;
                  data_len_q <= data_len_q + 16'd1;
                  // StData picks up a download that ended during the write
                  state_q    <= StData;
               end
            end
            StPatch: begin
               if (!mem_req_q) begin
                  mem_addr_q  <= patch_addr(type_q, patch_idx_q);
                  mem_wdata_q <= patch_data(patch_idx_q, start_q, end_addr);
                  mem_req_q   <= 1'b1;
               end else if (bus.mem_ack) begin
                  mem_req_q <= 1'b0;
                  if (patch_idx_q == patch_last(type_q)) begin
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     patch_idx_q <= patch_idx_q + 2'd1;
                  end
               end
            end
            StDone: begin
               cpu_wait_q <= 1'b0;
               busy_q     <= 1'b0;
               state_q    <= StIdle;
            end
            StErr: begin
               if (!bus.dn_download) begin
                  cpu_wait_q <= 1'b0;
                  busy_q     <= 1'b0;
                  state_q    <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.dn_wait   = dn_wait_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign cpu_wait      = cpu_wait_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;

endmodule

// File: tb/tb_vz_loader.sv
// Self-checking bench for vz_loader: builds .VZ files, predicts the RAM write sequence from
// the file contents, and checks every granted write, stall behaviour and status flags.
module tb_vz_loader;

   logic clk = 1'b0;
   logic rst_n;
   logic cpu_wait, busy, done, err;

   vz_loader_if bus ();

   vz_loader dut (
      .CLK10MHZ (clk),
      .RESET    (rst_n),
      .bus      (bus),
      .cpu_wait (cpu_wait),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
      bit          is_data;
   } wr_t;

   wr_t        exp_q[$];
   logic [7:0] file_q[$];
   int         n_pass = 0;
   int         n_total = 0;
   int         done_cnt = 0;
   int         ack_delay = 0;
   bit         req_allowed = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, req);
   endtask

   // Memory arbiter model and write comparator
   initial begin : responder
      int  wait_cnt;
      wr_t w;
      wait_cnt    = 0;
      bus.mem_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (!req_allowed) check("no_mem_req", bus.mem_req, 0);
         if (bus.mem_ack) begin
            bus.mem_ack = 1'b0;
         end else if (!bus.mem_req) begin
            wait_cnt = 0;
         end else if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_write: got %h=%h, want no write", bus.mem_addr,
                     bus.mem_wdata);
            bus.mem_ack = 1'b1;
         end else if (wait_cnt < ack_delay) begin
            check("write_hold", {8'h0, bus.mem_addr, bus.mem_wdata},
                  {8'h0, exp_q[0].a, exp_q[0].d});
            if (exp_q[0].is_data) check("dn_wait_hold", bus.dn_wait, 1);
            wait_cnt++;
         end else begin
            w = exp_q.pop_front();
            check("write", {8'h0, bus.mem_addr, bus.mem_wdata}, {8'h0, w.a, w.d});
            if (w.is_data) check("dn_wait_write", bus.dn_wait, 1);
            bus.mem_ack = 1'b1;
            wait_cnt    = 0;
         end
      end
   end

   initial begin : done_mon
      forever begin
         @(negedge clk);
         if (done) done_cnt++;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation still running, want finished");
      $fatal(1);
   end

   task automatic build_file(input logic [31:0] magic, input logic [7:0] typ,
                             input logic [15:0] start, input int n, input logic [7:0] seed);
      logic [7:0] b;
      file_q.delete();
      for (int i = 0; i < 4; i++) file_q.push_back(magic[31-8*i -: 8]);
      for (int i = 4; i < 21; i++) file_q.push_back(8'h41 + 8'(i));
      file_q.push_back(typ);
      file_q.push_back(start[7:0]);
      file_q.push_back(start[15:8]);
      for (int i = 0; i < n; i++) begin
         b = seed + 8'(8'h11 * i);
         file_q.push_back(b);
      end
   endtask

   task automatic push_wr(input logic [15:0] a, input logic [7:0] d, input bit is_data);
      wr_t w;
      w.a = a;
      w.d = d;
      w.is_data = is_data;
      exp_q.push_back(w);
   endtask

   // Expected RAM writes: data bytes at start+i, then the ROM pointer patches
   task automatic model_expect(input logic [7:0] typ, input logic [15:0] start, input int n);
      logic [15:0] end_a;
      exp_q.delete();
      for (int i = 0; i < n; i++) push_wr(start + 16'(i), file_q[24+i], 1'b1);
      end_a = start + 16'(n);
      if (typ == 8'hF0) begin
         push_wr(16'h78A4, start[7:0], 1'b0);
         push_wr(16'h78A5, start[15:8], 1'b0);
         push_wr(16'h78F9, end_a[7:0], 1'b0);
         push_wr(16'h78FA, end_a[15:8], 1'b0);
      end else begin
         push_wr(16'h788E, start[7:0], 1'b0);
         push_wr(16'h788F, start[15:8], 1'b0);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (bus.dn_wait && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (bus.dn_wait) begin
         n_total++;
         $display("FAIL dn_wait_timeout: dn_wait=1 after 100 cycles, want 0");
      end
   endtask

   task automatic send_byte(input logic [15:0] a, input logic [7:0] d, input bit do_wait);
      bus.dn_addr = a;
      bus.dn_data = d;
      bus.dn_wr   = 1'b1;
      @(negedge clk);
      bus.dn_wr = 1'b0;
      if (do_wait) wait_ready();
   endtask

   // Stream the file; drop_at >= 0 ends the download early, viol_at injects a stalled strobe
   task automatic run_file(input int drop_at, input int viol_at);
      int last;
      last = (drop_at >= 0) ? drop_at : file_q.size();
      done_cnt        = 0;
      bus.dn_index    = 8'd1;
      bus.dn_download = 1'b1;
      @(negedge clk);
      for (int i = 0; i < last; i++) begin
         if (i == viol_at) begin
            send_byte(16'(i), file_q[i], 1'b0);
            check("dn_wait_before_violation", bus.dn_wait, 1);
            send_byte(16'hBEEF, 8'hEE, 1'b1);
         end else begin
            send_byte(16'(i), file_q[i], 1'b1);
         end
         if (i == 0) begin
            check("busy_active", busy, 1);
            check("cpu_wait_active", cpu_wait, 1);
            check("err_cleared_on_start", err, 0);
         end
      end
      bus.dn_download = 1'b0;
   endtask

   task automatic finish_load(input string name, input bit exp_err, input int exp_done);
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check({name, "_idle"}, busy, 0);
      check({name, "_writes_left"}, exp_q.size(), 0);
      check({name, "_done_pulses"}, done_cnt, exp_done);
      check({name, "_err"}, err, exp_err);
      check({name, "_cpu_wait"}, cpu_wait, 0);
   endtask

   initial begin : main
      rst_n           = 1'b0;
      bus.dn_download = 1'b0;
      bus.dn_index    = 8'd0;
      bus.dn_wr       = 1'b0;
      bus.dn_addr     = 16'd0;
      bus.dn_data     = 8'd0;
      repeat (3) @(negedge clk);
      check("rst_dn_wait", bus.dn_wait, 0);
      check("rst_mem_req", bus.mem_req, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      check("rst_cpu_wait", cpu_wait, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Other download slots are ignored
      bus.dn_index    = 8'd2;
      bus.dn_download = 1'b1;
      repeat (3) @(negedge clk);
      check("other_index_ignored", busy, 0);
      bus.dn_download = 1'b0;
      @(negedge clk);

      // BASIC load
      build_file(32'h565A_4630, 8'hF0, 16'h7AE9, 3, 8'h11);
      model_expect(8'hF0, 16'h7AE9, 3);
      check("pin_basic_data2", {exp_q[2].a, exp_q[2].d}, {16'h7AEB, 8'h33});
      check("pin_basic_start_lo", {exp_q[3].a, exp_q[3].d}, {16'h78A4, 8'hE9});
      check("pin_basic_start_hi", {exp_q[4].a, exp_q[4].d}, {16'h78A5, 8'h7A});
      check("pin_basic_end_lo", {exp_q[5].a, exp_q[5].d}, {16'h78F9, 8'hEC});
      check("pin_basic_end_hi", {exp_q[6].a, exp_q[6].d}, {16'h78FA, 8'h7A});
      run_file(-1, -1);
      finish_load("basic", 1'b0, 1);

      // Binary load
      build_file(32'h565A_4630, 8'hF1, 16'h8000, 1, 8'h5A);
      model_expect(8'hF1, 16'h8000, 1);
      check("pin_bin_lo", {exp_q[1].a, exp_q[1].d}, {16'h788E, 8'h00});
      check("pin_bin_hi", {exp_q[2].a, exp_q[2].d}, {16'h788F, 8'h80});
      run_file(-1, -1);
      finish_load("binary", 1'b0, 1);

      // Bad magic: no RAM traffic, sticky error
      build_file(32'h4142_4344, 8'hF0, 16'h7AE9, 3, 8'h11);
      exp_q.delete();
      req_allowed = 1'b0;
      run_file(-1, -1);
      check("bad_magic_dn_wait", bus.dn_wait, 0);
      finish_load("bad_magic", 1'b1, 0);
      req_allowed = 1'b1;

      // Slow arbiter, alternate magic; start-of-load clears the old error
      build_file(32'h2020_0000, 8'hF0, 16'h4000, 4, 8'h21);
      model_expect(8'hF0, 16'h4000, 4);
      ack_delay = 5;
      run_file(-1, -1);
      finish_load("slow_ack", 1'b0, 1);

      // Download ends inside the header
      build_file(32'h565A_4630, 8'hF0, 16'h7AE9, 3, 8'h11);
      exp_q.delete();
      ack_delay   = 0;
      req_allowed = 1'b0;
      run_file(10, -1);
      @(negedge clk);
      check("trunc_err_early", err, 1);
      finish_load("truncated", 1'b1, 0);
      req_allowed = 1'b1;

      // Strobe while stalled: byte dropped, write completes, error latched
      build_file(32'h565A_4630, 8'hF1, 16'h6000, 3, 8'h07);
      model_expect(8'hF1, 16'h6000, 3);
      ack_delay = 5;
      run_file(-1, 25);
      finish_load("violation", 1'b1, 1);
      ack_delay = 0;

      // Address wrap
      build_file(32'h565A_4630, 8'hF0, 16'hFFFE, 3, 8'h40);
      model_expect(8'hF0, 16'hFFFE, 3);
      check("pin_wrap_addr", exp_q[2].a, 16'h0000);
      check("pin_wrap_end_lo", {exp_q[5].a, exp_q[5].d}, {16'h78F9, 8'h01});
      check("pin_wrap_end_hi", {exp_q[6].a, exp_q[6].d}, {16'h78FA, 8'h00});
      run_file(-1, -1);
      finish_load("wrap", 1'b0, 1);

      // No data bytes: end equals start
      build_file(32'h565A_4630, 8'hF0, 16'h1234, 0, 8'h00);
      model_expect(8'hF0, 16'h1234, 0);
      check("pin_zero_end_lo", {exp_q[2].a, exp_q[2].d}, {16'h78F9, 8'h34});
      run_file(-1, -1);
      finish_load("zero_len", 1'b0, 1);

      // Reset while a data write waits for its grant
      build_file(32'h565A_4630, 8'hF0, 16'h9000, 2, 8'h10);
      model_expect(8'hF0, 16'h9000, 2);
      ack_delay       = 1000;
      bus.dn_index    = 8'd1;
      bus.dn_download = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 24; i++) send_byte(16'(i), file_q[i], 1'b1);
      send_byte(16'd24, file_q[24], 1'b0);
      repeat (2) @(negedge clk);
      check("pre_reset_mem_req", bus.mem_req, 1);
      check("pre_reset_cpu_wait", cpu_wait, 1);
      #2 rst_n = 1'b0;
      #1;
      check("reset_mem_req", bus.mem_req, 0);
      check("reset_cpu_wait", cpu_wait, 0);
      check("reset_busy", busy, 0);
      check("reset_dn_wait", bus.dn_wait, 0);
      exp_q.delete();
      bus.dn_download = 1'b0;
      ack_delay       = 0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("after_reset_idle", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
